intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Prioritised interrupt controller feeding the CPU's single Intr/Inta interrupt handshake.
- Synchronises up to 8 external request lines and latches them as pending bits.
- Applies a software-written enable mask and the CPU global enable (Status bit 9).
- Presents one winning request to the control unit, holds it until acknowledged, then blocks further requests until eret.

Parameters:
N_SRC, 8, number of interrupt sources (1..8).
EDGE_MODE, 1, 1 = rising-edge-triggered sticky pending bits; 0 = level-triggered, pending follows synchronised input.
EN_RST, 8'h00, reset value of the enable mask register.

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Clrn  input  1  asynchronous active-low reset.
Irq  input  N_SRC  raw external request lines, asynchronous to Clk.
Ie  input  1  global interrupt enable, driven from Status[9].
En_we  input  1  write strobe for the enable mask (mtc0 to mask register).
En_wdata  input  N_SRC  new enable mask value; bit i = 1 enables source i.
Inta  input  1  acknowledge from the control unit; one-cycle pulse.
Eret  input  1  eret executed; one-cycle pulse.
Intr  output  1  interrupt request to the control unit.
Irq_id  output  3  index of the source being requested or serviced.
Cause  output  32  cause value for the Cause register: [15:8] pending snapshot at grant (zero-extended), [6:2] = 0 (interrupt ExcCode), other bits 0.
Pending  output  N_SRC  current pending bits (debug / mfc0 readback).
In_service  output  1  1 while the handler runs (Inta accepted, Eret not yet seen).

Behaviour:
- Reset (Clrn low, asynchronous): state IDLE; Intr=0, Irq_id=0, Cause=0, Pending=0, In_service=0; synchronisers=0; enable mask=EN_RST. Reset mid-handshake aborts it with no residue.
- Input path: 2-flop synchroniser per bit (s1, s2), plus a previous-value flop s3.
  - EDGE_MODE=1: pending[i] is set when s2 & ~s3.
  - EDGE_MODE=0: pending[i] = s2.
- Enable mask: written on En_we at the next edge, effective the following cycle. Masking never clears pending bits.
- Eligible = Pending & mask. The winner is the lowest set index (source 0 has highest priority).
- IDLE:
  - If Ie & |Eligible: latch Irq_id = winner and Cause[15:8] = Pending; go to REQ.
  - Intr is registered and goes high on the same edge as the REQ entry.
- REQ:
  - Intr=1; Irq_id and Cause are held stable and never re-arbitrated, even if a higher-priority source arrives.
  - If Inta: clear pending[Irq_id] (EDGE_MODE=1 only); Intr=0, In_service=1; go to SERVICE.
  - Else if ~Ie or ~Eligible[Irq_id] (request withdrawn, e.g. masked): Intr=0; go to IDLE.
  - Inta and withdrawal in the same cycle: Inta wins.
- SERVICE:
  - Intr stays 0 regardless of new requests (no nesting).
  - On Eret: In_service=0; go to IDLE. Re-arbitration is possible the next cycle.
  - New requests keep accumulating in the pending bits.
- Inta outside REQ and Eret outside SERVICE are ignored.
- A new rising edge on source i in the same cycle that pending[i] is cleared by Inta: the set wins, and pending[i] stays 1.
- Latency: in IDLE with Ie=1 and the source enabled, Intr is high after the 4th rising edge following the Irq rise (edges: s1, s2, pending, state/Intr). The Inta-to-Intr-low latency is 1 edge.
- Ie low in IDLE: no request is raised; pending bits are retained.

Test Plan:
- Reset, mask=8'hFF, Ie=1, Irq[3] rises → Intr=1 on the 4th edge with Irq_id=3 and Cause=32'h0000_0800; pulse Inta → next cycle Intr=0, In_service=1, Pending[3]=0.
- Irq[5] and Irq[2] rise together → Irq_id=2 and Cause[15:8]=8'h24; after Inta then Eret → second request with Irq_id=5 and Cause[15:8]=8'h20.
- In REQ for source 4, write mask=8'hEF (disable source 4) → Intr drops after 1 edge, state IDLE, Pending[4] still 1; re-enable → Intr reasserted with Irq_id=4.
- In SERVICE, Irq[0] rises → Intr stays 0 and Pending[0]=1; Eret → Intr=1 with Irq_id=0 one edge later.
- Ie=0 with Irq[1] pending → Intr stays 0 for 20 cycles; set Ie=1 → Intr=1 after 1 edge.
- Drive Clrn low during REQ → all outputs 0 immediately (asynchronous); mask returns to 8'h00.

Source files
------------

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller for the CPU's Intr/Inta handshake.
// External request lines are synchronised and latched as pending bits, then
// filtered by a software enable mask and the global enable. The lowest-index
// eligible source wins, is held on Intr until acknowledged, and blocks
// further requests until eret.
//
// Ports:
//   Clk, Clrn   clock and asynchronous active-low reset
//   Irq         raw request lines (asynchronous to Clk)
//   Ie          global interrupt enable (Status[9])
//   En_we       enable mask write strobe
//   En_wdata    new enable mask value
//   Inta        acknowledge pulse from the control unit
//   Eret        eret executed pulse
//   Intr        interrupt request to the control unit
//   Irq_id      index of the source being requested or serviced
//   Cause       cause value: [15:8] pending snapshot at grant, rest zero
//   Pending     current pending bits
//   In_service  handler running (Inta accepted, Eret not yet seen)
module intr_ctrl #(
  parameter int unsigned N_SRC     = 8,
  parameter bit          EDGE_MODE = 1'b1,
  parameter logic [7:0]  EN_RST    = 8'h00
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [N_SRC-1:0] Irq,
  input  logic             Ie,
  input  logic             En_we,
  input  logic [N_SRC-1:0] En_wdata,
  input  logic             Inta,
  input  logic             Eret,
  output logic             Intr,
  output logic [2:0]       Irq_id,
  output logic [31:0]      Cause,
  output logic [N_SRC-1:0] Pending,
  output logic             In_service
);

  localparam int unsigned ID_W    = 3;
  localparam int unsigned SNAP_W  = 8;
  localparam int unsigned CAUSE_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t            state;
  logic [N_SRC-1:0]  s1;
  logic [N_SRC-1:0]  s2;
  logic [N_SRC-1:0]  en_mask;
  logic [N_SRC-1:0]  eligible;
  logic [ID_W-1:0]   winner;
  logic              ack;

  // Two-flop synchroniser for the asynchronous request lines
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= Irq;
      s2 <= s1;
    end
  end

  // Software enable mask; masking never touches the pending bits
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      en_mask <= EN_RST[N_SRC-1:0];
    end else if (En_we) begin
      en_mask <= En_wdata;
    end
  end

  assign eligible = Pending & en_mask;
  assign ack      = (state == REQ) && Inta;

  // Fixed priority: lowest set index wins
  always_comb begin
    winner = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  generate
    if (EDGE_MODE) begin : g_edge
      logic [N_SRC-1:0] s3;
      logic [N_SRC-1:0] rise;
      logic [N_SRC-1:0] clr;

      assign rise = s2 & ~s3;
      assign clr  = ack ? (N_SRC'(1) << Irq_id) : '0;

      // Sticky pending; a fresh edge outranks a same-cycle acknowledge clear
      always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          s3      <= '0;
          Pending <= '0;
        end else begin
          s3      <= s2;
          Pending <= (Pending & ~clr) | rise;
        end
      end
    end else begin : g_level
      // Level mode: pending simply tracks the synchronised input
      always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          Pending <= '0;
        end else begin
          Pending <= s2;
        end
      end
    end
  endgenerate

  // Handshake FSM; Irq_id and Cause are latched only on grant
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state      <= IDLE;
      Intr       <= 1'b0;
      Irq_id     <= '0;
      Cause      <= '0;
      In_service <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Ie && (|eligible)) begin
            state  <= REQ;
            Intr   <= 1'b1;
            Irq_id <= winner;
            Cause  <= CAUSE_W'({SNAP_W'(Pending), 8'h00});
          end
        end
        REQ: begin
          if (Inta) begin
            state      <= SERVICE;
            Intr       <= 1'b0;
            In_service <= 1'b1;
          end else if (!Ie || !eligible[Irq_id]) begin
            // Request withdrawn before acknowledge
            state <= IDLE;
            Intr  <= 1'b0;
          end
        end
        SERVICE: begin
          if (Eret) begin
            state      <= IDLE;
            In_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          Intr       <= 1'b0;
          In_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the controller.
module tb_intr_ctrl;

  localparam int unsigned N = 8;

  logic          Clk  = 1'b0;
  logic          Clrn = 1'b1;
  logic [N-1:0]  Irq;
  logic          Ie;
  logic          En_we;
  logic [N-1:0]  En_wdata;
  logic          Inta;
  logic          Eret;
  logic          Intr;
  logic [2:0]    Irq_id;
  logic [31:0]   Cause;
  logic [N-1:0]  Pending;
  logic          In_service;

  int total = 0;
  int bad   = 0;

  // Model state: input history, pending/mask, and handshake flags
  logic [N-1:0] m_d1, m_d2, m_d3, m_pend, m_mask;
  logic         m_intr, m_serv;
  logic [2:0]   m_id;
  logic [31:0]  m_cause;

  always #5 Clk = ~Clk;

  intr_ctrl #(.N_SRC(N), .EDGE_MODE(1'b1), .EN_RST(8'h00)) dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .Irq        (Irq),
    .Ie         (Ie),
    .En_we      (En_we),
    .En_wdata   (En_wdata),
    .Inta       (Inta),
    .Eret       (Eret),
    .Intr       (Intr),
    .Irq_id     (Irq_id),
    .Cause      (Cause),
    .Pending    (Pending),
    .In_service (In_service)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_d3 = '0;
    m_pend = '0; m_mask = 8'h00;
    m_intr = 1'b0; m_serv = 1'b0;
    m_id = '0; m_cause = '0;
  endtask

  // Advance the model by one rising edge using the inputs present now
  task automatic model_edge();
    logic [N-1:0] elig;
    logic [N-1:0] clr;
    logic [N-1:0] rise;
    elig = m_pend & m_mask;
    rise = m_d2 & ~m_d3;
    clr  = '0;
    if (!m_intr && !m_serv) begin
      if (Ie && elig != '0) begin
        m_id    = lowest(elig);
        m_cause = {16'h0000, m_pend, 8'h00};
        m_intr  = 1'b1;
      end
    end else if (m_intr) begin
      if (Inta) begin
        clr[m_id] = 1'b1;
        m_intr    = 1'b0;
        m_serv    = 1'b1;
      end else if (!Ie || !elig[m_id]) begin
        m_intr = 1'b0;
      end
    end else if (Eret) begin
      m_serv = 1'b0;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (En_we) m_mask = En_wdata;
    m_d3 = m_d2;
    m_d2 = m_d1;
    m_d1 = Irq;
  endtask

  task automatic check_all();
    chk("intr",       32'(Intr),       32'(m_intr));
    chk("irq_id",     32'(Irq_id),     32'(m_id));
    chk("cause",      Cause,           m_cause);
    chk("pending",    32'(Pending),    32'(m_pend));
    chk("in_service", 32'(In_service), 32'(m_serv));
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    Irq = '0; Ie = 1'b0; En_we = 1'b0; En_wdata = '0; Inta = 1'b0; Eret = 1'b0;
    model_reset();
    #1 Clrn = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    chk("rst_intr", 32'(Intr), 32'h0);
    chk("rst_cause", Cause, 32'h0);
    Clrn = 1'b1;

    // Single source, full latency and acknowledge
    En_we = 1'b1; En_wdata = 8'hFF;
    cyc();
    En_we = 1'b0; Ie = 1'b1; Irq = 8'h08;
    repeat (3) begin
      cyc();
      chk("lat_low", 32'(Intr), 32'h0);
    end
    cyc();
    chk("lat_intr", 32'(Intr), 32'h1);
    chk("lat_id", 32'(Irq_id), 32'd3);
    chk("lat_cause", Cause, 32'h0000_0800);
    Inta = 1'b1;
    cyc();
    Inta = 1'b0;
    chk("ack_intr", 32'(Intr), 32'h0);
    chk("ack_serv", 32'(In_service), 32'h1);
    chk("ack_pend3", 32'(Pending[3]), 32'h0);
    Eret = 1'b1;
    cyc();
    Eret = 1'b0; Irq = '0;
    chk("eret_serv", 32'(In_service), 32'h0);
    cyc();

    // Two simultaneous sources: priority and back-to-back service
    Irq = 8'h24;
    repeat (4) cyc();
    chk("pri_id", 32'(Irq_id), 32'd2);
    chk("pri_cause", Cause, 32'h0000_2400);
    Inta = 1'b1; cyc(); Inta = 1'b0;
    Eret = 1'b1; cyc(); Eret = 1'b0;
    cyc();
    chk("pri2_intr", 32'(Intr), 32'h1);
    chk("pri2_id", 32'(Irq_id), 32'd5);
    chk("pri2_cause", Cause, 32'h0000_2000);
    Inta = 1'b1; cyc(); Inta = 1'b0;
    Eret = 1'b1; cyc(); Eret = 1'b0; Irq = '0;
    cyc();

    // Withdrawal by masking, then re-enable
    Irq = 8'h10;
    repeat (4) cyc();
    chk("m_req_id", 32'(Irq_id), 32'd4);
    En_we = 1'b1; En_wdata = 8'hEF;
    cyc();
    En_we = 1'b0;
    cyc();
    chk("m_drop", 32'(Intr), 32'h0);
    chk("m_keep_pend", 32'(Pending[4]), 32'h1);
    En_we = 1'b1; En_wdata = 8'hFF;
    cyc();
    En_we = 1'b0;
    cyc();
    chk("m_reassert", 32'(Intr), 32'h1);
    chk("m_reassert_id", 32'(Irq_id), 32'd4);
    Inta = 1'b1; cyc(); Inta = 1'b0;
    Eret = 1'b1; cyc(); Eret = 1'b0; Irq = '0;
    cyc();

    // No nesting: request arrives during service
    Irq = 8'h40;
    repeat (4) cyc();
    Inta = 1'b1; cyc(); Inta = 1'b0;
    Irq = 8'h41;
    repeat (4) begin
      cyc();
      chk("nest_low", 32'(Intr), 32'h0);
    end
    chk("nest_pend0", 32'(Pending[0]), 32'h1);
    Eret = 1'b1; cyc(); Eret = 1'b0;
    cyc();
    chk("nest_intr", 32'(Intr), 32'h1);
    chk("nest_id", 32'(Irq_id), 32'd0);
    Inta = 1'b1; cyc(); Inta = 1'b0;
    Eret = 1'b1; cyc(); Eret = 1'b0; Irq = '0;
    cyc();

    // Global enable low holds off the request
    Ie = 1'b0; Irq = 8'h02;
    repeat (3) cyc();
    repeat (20) begin
      cyc();
      chk("ie_low", 32'(Intr), 32'h0);
    end
    Ie = 1'b1;
    cyc();
    chk("ie_intr", 32'(Intr), 32'h1);
    chk("ie_id", 32'(Irq_id), 32'd1);

    // Asynchronous reset in the middle of a request
    #2 Clrn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_intr", 32'(Intr), 32'h0);
    @(negedge Clk);
    Clrn = 1'b1; Irq = 8'h01;
    repeat (8) begin
      cyc();
      chk("arst_mask0", 32'(Intr), 32'h0);
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) Irq = 8'($urandom);
      Ie       = ($urandom_range(0, 7) != 0);
      Inta     = ($urandom_range(0, 2) == 0);
      Eret     = ($urandom_range(0, 3) == 0);
      En_we    = ($urandom_range(0, 9) == 0);
      En_wdata = 8'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
